control_unit_fsm: RTL and testbench

//  Multi-cycle control unit for the 16-bit RISC core. It sits upstream of the datapath and drives all cu_* controls.

---
 rtl/control_unit_fsm.sv | 205 ++++++++++++++++++++
 tb/tb_control_unit_fsm.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit_fsm.sv
// rtl/control_unit_fsm.sv - multi-cycle fetch/decode/execute control unit for the 16-bit RISC core
module control_unit_fsm #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            CLK100MHZ,
    input  logic            CPU_RESETN,
    output logic            mem_req,
    output logic            mem_we,
    output logic [PC_W-1:0] mem_addr,
    output logic [15:0]     mem_wdata,
    input  logic            mem_ack,
    input  logic [15:0]     mem_rdata,
    input  logic [15:0]     dp_a_data,
    input  logic            dp_zf_flag,
    output logic [7:0]      cu_imm,
    output logic [1:0]      cu_sel,
    output logic [3:0]      cu_write_addr,
    output logic            cu_write,
    output logic [3:0]      cu_a_addr,
    output logic            cu_a_read,
    output logic [3:0]      cu_b_addr,
    output logic            cu_b_read,
    output logic [3:0]      cu_alu_sel,
    output logic [PC_W-1:0] pc_out,
    output logic            halted
);

    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_LD   = 4'h9;
    localparam logic [3:0] OP_ST   = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_JZ   = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hE;

    localparam logic [1:0] SEL_ALU = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_IMM = 2'b10;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_HALT
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_next;
    logic [15:0]     ir;
    logic [15:0]     ir_next;

    // Instruction fields
    logic [3:0]      op;
    logic [3:0]      rd_field;
    logic [3:0]      ra_field;
    logic [3:0]      rb_field;
    logic [7:0]      imm8;
    logic [PC_W-1:0] imm_addr;
    logic            is_alu;
    logic [3:0]      a_field;

    assign op       = ir[15:12];
    assign rd_field = ir[11:8];
    assign ra_field = ir[7:4];
    assign rb_field = ir[3:0];
    assign imm8     = ir[7:0];
    assign imm_addr = PC_W'(imm8);
    assign is_alu   = ~op[3];

    // ST and JZ carry their source register in the rd slot; everything else reads ra.
    assign a_field  = ((op == OP_ST) || (op == OP_JZ)) ? rd_field : ra_field;

    assign pc_out   = pc;
    assign halted   = (state == ST_HALT);

    // State, PC and IR registers; reset abandons any request in flight.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state <= ST_BOOT;
            pc    <= RESET_PC;
            ir    <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            ir    <= ir_next;
        end
    end

    // Next state, PC update on fetch ack and branch resolution in EXEC.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        ir_next    = ir;
        case (state)
            ST_BOOT: begin
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_ack) begin
                    ir_next    = mem_rdata;
                    pc_next    = pc + PC_W'(1);
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_next = ST_EXEC;
            end
            ST_EXEC: begin
                state_next = ST_FETCH;
                case (op)
                    OP_LD, OP_ST: state_next = ST_MEM;
                    OP_JMP:       pc_next    = imm_addr;
                    OP_JZ: begin
                        if (dp_zf_flag) begin
                            pc_next = imm_addr;
                        end
                    end
                    OP_HALT:      state_next = ST_HALT;
                    default:      state_next = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (mem_ack) begin
                    state_next = ST_FETCH;
                end
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_BOOT;
            end
        endcase
    end

    // Control outputs decoded from state and IR; the LD write strobe also follows mem_ack.
    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        cu_imm        = '0;
        cu_sel        = SEL_ALU;
        cu_write_addr = '0;
        cu_write      = 1'b0;
        cu_a_addr     = '0;
        cu_a_read     = 1'b0;
        cu_b_addr     = '0;
        cu_b_read     = 1'b0;
        cu_alu_sel    = '0;

        // Register addresses stay on the bus from DECODE until the instruction retires
        // so A data remains valid for ST write data and the JZ zero flag.
        if ((state == ST_DECODE) || (state == ST_EXEC) || (state == ST_MEM)) begin
            cu_a_addr = a_field;
            cu_b_addr = rb_field;
            cu_a_read = 1'b1;
            cu_b_read = 1'b1;
            if (is_alu) begin
                cu_alu_sel = {1'b0, op[2:0]};
            end
        end

        case (state)
            ST_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc;
            end
            ST_EXEC: begin
                if (is_alu) begin
                    cu_sel        = SEL_ALU;
                    cu_write      = 1'b1;
                    cu_write_addr = rd_field;
                end else if (op == OP_LDI) begin
                    cu_sel        = SEL_IMM;
                    cu_imm        = imm8;
                    cu_write      = 1'b1;
                    cu_write_addr = rd_field;
                end
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                mem_addr = imm_addr;
                if (op == OP_ST) begin
                    mem_we    = 1'b1;
                    mem_wdata = dp_a_data;
                end else begin
                    cu_write_addr = rd_field;
                    if (mem_ack) begin
                        cu_sel   = SEL_MEM;
                        cu_write = 1'b1;
                    end
                end
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_control_unit_fsm.sv
// tb/tb_control_unit_fsm.sv - self-checking bench for control_unit_fsm against an ISA-level model
module tb_control_unit_fsm;

    localparam int PC_W = 8;

    logic            CLK100MHZ = 1'b0;
    logic            CPU_RESETN;
    logic            mem_req;
    logic            mem_we;
    logic [PC_W-1:0] mem_addr;
    logic [15:0]     mem_wdata;
    logic            mem_ack;
    logic [15:0]     mem_rdata;
    logic [15:0]     dp_a_data;
    logic            dp_zf_flag;
    logic [7:0]      cu_imm;
    logic [1:0]      cu_sel;
    logic [3:0]      cu_write_addr;
    logic            cu_write;
    logic [3:0]      cu_a_addr;
    logic            cu_a_read;
    logic [3:0]      cu_b_addr;
    logic            cu_b_read;
    logic [3:0]      cu_alu_sel;
    logic [PC_W-1:0] pc_out;
    logic            halted;

    control_unit_fsm #(.PC_W(PC_W), .RESET_PC(8'h00)) dut (
        .CLK100MHZ    (CLK100MHZ),
        .CPU_RESETN   (CPU_RESETN),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .dp_a_data    (dp_a_data),
        .dp_zf_flag   (dp_zf_flag),
        .cu_imm       (cu_imm),
        .cu_sel       (cu_sel),
        .cu_write_addr(cu_write_addr),
        .cu_write     (cu_write),
        .cu_a_addr    (cu_a_addr),
        .cu_a_read    (cu_a_read),
        .cu_b_addr    (cu_b_addr),
        .cu_b_read    (cu_b_read),
        .cu_alu_sel   (cu_alu_sel),
        .pc_out       (pc_out),
        .halted       (halted)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
    } mem_t;

    typedef struct packed {
        logic [3:0] addr;
        logic [1:0] sel;
        logic [7:0] imm;
        logic [3:0] alu;
        logic [3:0] a;
        logic [3:0] b;
    } wr_t;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] mem [256];
    logic [15:0] dmem [256];
    logic        dmem_vld [256];
    logic [15:0] regs [16];
    logic [15:0] model_mem [256];
    logic [15:0] mregs [16];

    int first_wait;
    int all_wait;
    int req_cnt;
    int txn_idx;
    logic checking;

    mem_t exp_mem [$];
    wr_t  exp_wr [$];
    logic [7:0]  seen_addr [$];
    logic [15:0] seen_wdata [$];
    logic [25:0] seen_wr [$];
    int req_cycles_first;

    logic        prev_req;
    logic        prev_ack;
    logic        prev_write;
    logic [24:0] prev_bus;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] alu(input logic [3:0] s, input logic [15:0] a, input logic [15:0] b);
        case (s)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << 1;
            4'd6:    return a >> 1;
            default: return ~a;
        endcase
    endfunction

    function automatic int wait_for(input int idx);
        return (idx == 0) ? first_wait : all_wait;
    endfunction

    // Datapath stand-in: register file written from the selected source, A port read combinationally.
    assign dp_a_data  = regs[cu_a_addr];
    assign dp_zf_flag = (dp_a_data == 16'h0);

    always @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else if (cu_write) begin
            case (cu_sel)
                2'b00:   regs[cu_write_addr] <= alu(cu_alu_sel, regs[cu_a_addr], regs[cu_b_addr]);
                2'b01:   regs[cu_write_addr] <= mem_rdata;
                2'b10:   regs[cu_write_addr] <= {8'h00, cu_imm};
                default: ;
            endcase
        end
    end

    // Memory with per-transaction wait states; stores land in a shadow data array.
    task responder();
        forever begin
            @(posedge CLK100MHZ);
            #2;
            if (!CPU_RESETN) begin
                mem_ack   = 1'b0;
                mem_rdata = '0;
                req_cnt   = 0;
                txn_idx   = 0;
                for (int i = 0; i < 256; i++) dmem_vld[i] = 1'b0;
            end else if (mem_req) begin
                if (req_cnt >= wait_for(txn_idx)) begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        dmem[mem_addr]     = mem_wdata;
                        dmem_vld[mem_addr] = 1'b1;
                        mem_rdata          = '0;
                    end else begin
                        mem_rdata = dmem_vld[mem_addr] ? dmem[mem_addr] : mem[mem_addr];
                    end
                    req_cnt = 0;
                    txn_idx++;
                end else begin
                    mem_ack = 1'b0;
                    req_cnt++;
                end
            end else begin
                mem_ack = 1'b0;
                req_cnt = 0;
            end
        end
    endtask

    // Per-cycle comparison of bus transactions and register writes against the model queues.
    task compare_loop();
        mem_t m;
        wr_t  e;
        forever begin
            @(negedge CLK100MHZ);
            if (!CPU_RESETN || !checking) begin
                prev_req   = 1'b0;
                prev_ack   = 1'b0;
                prev_write = 1'b0;
            end else begin
                check("sel_legal", {31'b0, cu_sel == 2'b11}, 0);
                if (halted) check("halt_quiet", {mem_req, cu_write, mem_we}, 0);
                if (prev_req && !prev_ack) begin
                    check("req_held", mem_req, 1);
                    check("bus_stable", {mem_we, mem_addr, mem_wdata}, prev_bus);
                end
                if (mem_req && seen_addr.size() == 0) req_cycles_first++;
                if (mem_req && mem_ack) begin
                    check("mem_pending", exp_mem.size() != 0, 1);
                    if (exp_mem.size() != 0) begin
                        m = exp_mem.pop_front();
                        check("mem_we", mem_we, m.we);
                        check("mem_addr", mem_addr, m.addr);
                        if (m.we) check("mem_wdata", mem_wdata, m.wdata);
                    end
                    seen_addr.push_back(mem_addr);
                    if (mem_we) seen_wdata.push_back(mem_wdata);
                end
                if (cu_write) begin
                    check("write_gap", prev_write, 0);
                    check("write_pending", exp_wr.size() != 0, 1);
                    if (exp_wr.size() != 0) begin
                        e = exp_wr.pop_front();
                        check("write_addr", cu_write_addr, e.addr);
                        check("write_sel", cu_sel, e.sel);
                        if (e.sel == 2'b10) check("write_imm", cu_imm, e.imm);
                        if (e.sel == 2'b00) begin
                            check("write_alu", cu_alu_sel, e.alu);
                            check("write_rd_ports", {cu_a_addr, cu_b_addr, cu_a_read, cu_b_read}, {e.a, e.b, 2'b11});
                        end
                    end
                    seen_wr.push_back({cu_a_addr, cu_b_addr, cu_alu_sel, cu_write_addr, cu_sel, cu_imm});
                end
                prev_req   = mem_req;
                prev_ack   = mem_ack;
                prev_write = cu_write;
                prev_bus   = {mem_we, mem_addr, mem_wdata};
            end
        end
    endtask

    // Instruction-level reference: runs the program and lists the expected bus traffic and writes.
    task build_model(output int cyc, output logic [7:0] fpc);
        logic [15:0] ir;
        logic [7:0]  pc;
        logic [3:0]  op, rd, ra, rb;
        logic [7:0]  imm;
        int          tx;
        mem_t        m;
        wr_t         w;
        for (int i = 0; i < 256; i++) model_mem[i] = mem[i];
        for (int i = 0; i < 16; i++) mregs[i] = '0;
        exp_mem.delete();
        exp_wr.delete();
        pc  = 8'h00;
        cyc = 1;
        tx  = 0;
        for (int n = 0; n < 500; n++) begin
            ir = model_mem[pc];
            m.we = 1'b0; m.addr = pc; m.wdata = '0;
            exp_mem.push_back(m);
            cyc += 3 + wait_for(tx);
            tx++;
            pc  = pc + 8'd1;
            op  = ir[15:12]; rd = ir[11:8]; ra = ir[7:4]; rb = ir[3:0]; imm = ir[7:0];
            w.addr = rd; w.imm = 8'h00; w.alu = 4'h0; w.a = ra; w.b = rb; w.sel = 2'b00;
            if (op < 4'h8) begin
                mregs[rd] = alu(op, mregs[ra], mregs[rb]);
                w.alu = op;
                exp_wr.push_back(w);
            end else if (op == 4'h8) begin
                mregs[rd] = {8'h00, imm};
                w.sel = 2'b10; w.imm = imm;
                exp_wr.push_back(w);
            end else if (op == 4'h9 || op == 4'hA) begin
                m.we = (op == 4'hA); m.addr = imm; m.wdata = (op == 4'hA) ? mregs[rd] : 16'h0;
                exp_mem.push_back(m);
                cyc += 1 + wait_for(tx);
                tx++;
                if (op == 4'hA) begin
                    model_mem[imm] = mregs[rd];
                end else begin
                    mregs[rd] = model_mem[imm];
                    w.sel = 2'b01;
                    exp_wr.push_back(w);
                end
            end else if (op == 4'hB) begin
                pc = imm;
            end else if (op == 4'hC) begin
                if (mregs[rd] == 16'h0) pc = imm;
            end else if (op == 4'hE) begin
                break;
            end
        end
        fpc = pc;
    endtask

    task clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'hE000;
    endtask

    task run_test(input string name, input int fw, input int aw, input int lit_cycles);
        int          mcyc;
        logic [7:0]  mpc;
        int          cnt;
        CPU_RESETN = 1'b0;
        checking   = 1'b0;
        first_wait = fw;
        all_wait   = aw;
        repeat (2) @(negedge CLK100MHZ);
        build_model(mcyc, mpc);
        seen_addr.delete();
        seen_wdata.delete();
        seen_wr.delete();
        req_cycles_first = 0;
        checking   = 1'b1;
        CPU_RESETN = 1'b1;
        #1;
        check({name, "_boot_idle"}, mem_req, 0);
        cnt = 0;
        while (cnt < 3000) begin
            @(negedge CLK100MHZ);
            cnt++;
            if (cnt == 1) check({name, "_first_fetch"}, {mem_req, mem_addr}, {1'b1, 8'h00});
            if (halted) break;
        end
        check({name, "_cycles_model"}, cnt, mcyc);
        check({name, "_cycles_lit"}, cnt, lit_cycles);
        repeat (4) @(negedge CLK100MHZ);
        check({name, "_mem_drained"}, exp_mem.size(), 0);
        check({name, "_wr_drained"}, exp_wr.size(), 0);
        check({name, "_pc_frozen"}, pc_out, mpc);
        for (int i = 0; i < 16; i++) check({name, "_reg"}, regs[i], mregs[i]);
        checking = 1'b0;
    endtask

    task check_addr(input string name, input int idx, input logic [7:0] exp);
        if (idx < seen_addr.size()) check(name, seen_addr[idx], exp);
        else check({name, "_missing"}, seen_addr.size(), idx + 1);
    endtask

    logic [25:0] w0;

    initial begin
        CPU_RESETN = 1'b0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;
        checking   = 1'b0;
        first_wait = 0;
        all_wait   = 0;
        req_cnt    = 0;
        txn_idx    = 0;
        prev_req   = 1'b0;
        prev_ack   = 1'b0;
        prev_write = 1'b0;
        prev_bus   = '0;
        req_cycles_first = 0;
        clear_mem();
        fork
            responder();
            compare_loop();
        join_none

        // Outputs while reset is held
        repeat (3) @(negedge CLK100MHZ);
        check("reset_outputs", {mem_req, mem_we, mem_addr, mem_wdata, cu_imm, cu_sel, cu_write_addr, cu_write,
                                cu_a_addr, cu_a_read, cu_b_addr, cu_b_read, cu_alu_sel, halted}, 0);
        check("reset_pc", pc_out, 8'h00);

        // LDI R1,5 ; ADD R3,R1,R2 ; HALT with the first fetch stalled three cycles
        clear_mem();
        mem[0] = 16'h8105; mem[1] = 16'h0312; mem[2] = 16'hE000;
        run_test("ldi_add", 3, 0, 13);
        check("ldi_add_req_hold", req_cycles_first, 4);
        check_addr("ldi_add_f1", 1, 8'h01);
        check_addr("ldi_add_f2", 2, 8'h02);
        check("ldi_add_nwr", seen_wr.size(), 2);
        if (seen_wr.size() >= 2) begin
            w0 = seen_wr[0];
            check("ldi_exec", w0[13:0], {4'd1, 2'b10, 8'h05});
            w0 = seen_wr[1];
            check("add_exec", w0[25:8], {4'd1, 4'd2, 4'd0, 4'd3, 2'b00});
        end

        // JZ taken on zero, then not taken on non-zero
        clear_mem();
        mem[8'h00] = 16'h8400; mem[8'h01] = 16'hC420;
        mem[8'h20] = 16'h8401; mem[8'h21] = 16'hC430; mem[8'h22] = 16'hE000;
        run_test("jz", 0, 0, 16);
        check_addr("jz_taken", 2, 8'h20);
        check_addr("jz_not_taken", 4, 8'h22);

        // Store then load the same location, one wait state on every transaction
        clear_mem();
        mem[0] = 16'h8177; mem[1] = 16'hA140; mem[2] = 16'h9540; mem[3] = 16'hE000;
        run_test("st_ld", 1, 1, 21);
        check_addr("st_addr", 2, 8'h40);
        check_addr("ld_addr", 4, 8'h40);
        check("st_wdata", (seen_wdata.size() != 0) ? seen_wdata[0] : 16'hDEAD, 16'h0077);
        check("ld_reg5", regs[5], 16'h0077);
        if (seen_wr.size() >= 2) begin
            w0 = seen_wr[1];
            check("ld_write", w0[13:8], {4'd5, 2'b01});
        end else begin
            check("ld_write_count", seen_wr.size(), 2);
        end

        // PC wraps from 0xFF to 0x00
        clear_mem();
        mem[8'h00] = 16'hC1FF; mem[8'hFF] = 16'h8101; mem[8'h01] = 16'hE000;
        run_test("wrap", 0, 0, 13);
        check_addr("wrap_ff", 1, 8'hFF);
        check_addr("wrap_00", 2, 8'h00);
        check("wrap_pc", pc_out, 8'h02);

        // Reset during a stalled fetch, then an ALU/NOP/JMP/ST program from the reset PC
        clear_mem();
        mem[8'h00] = 16'h8105; mem[8'h01] = 16'h8203; mem[8'h02] = 16'h0312; mem[8'h03] = 16'h1412;
        mem[8'h04] = 16'h2512; mem[8'h05] = 16'h3612; mem[8'h06] = 16'hD000; mem[8'h07] = 16'hB00A;
        mem[8'h0A] = 16'h4712; mem[8'h0B] = 16'hA340; mem[8'h0C] = 16'hE000;
        first_wait = 50;
        all_wait   = 0;
        CPU_RESETN = 1'b0;
        repeat (2) @(negedge CLK100MHZ);
        CPU_RESETN = 1'b1;
        repeat (4) @(negedge CLK100MHZ);
        check("stall_req", {mem_req, mem_addr}, {1'b1, 8'h00});
        @(posedge CLK100MHZ);
        #3;
        CPU_RESETN = 1'b0;
        #1;
        check("rst_drop_req", mem_req, 0);
        check("rst_no_write", cu_write, 0);
        run_test("alu_mix", 0, 0, 35);
        check_addr("alu_mix_refetch", 0, 8'h00);
        check_addr("alu_mix_jmp", 8, 8'h0A);
        check("alu_mix_st", (seen_wdata.size() != 0) ? seen_wdata[0] : 16'hDEAD, 16'h0008);
        check("alu_mix_xor", regs[7], 16'h0006);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
